// File: rtl/risc_pkg.sv
// Shared definitions for the RISC fetch/decode slice: widths, opcode field, fetch FSM states.
package risc_pkg;

  localparam int unsigned IW = 16;

  localparam logic [3:0] LD = 4'b1110;
  localparam logic [3:0] ST = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [3:0] opcode(input logic [IW-1:0] instr);
    return instr[IW-1:IW-4];
  endfunction

endpackage

// File: rtl/risc_fetch_skid.sv
// One-entry data+tag holding register that catches a returning fetch word while decode stalls.
module risc_fetch_skid #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic          rd_i,
  input  logic          clr_i,
  input  logic [DW-1:0] data_i,
  input  logic [AW-1:0] tag_i,
  output logic          vld_o,
  output logic [DW-1:0] data_o,
  output logic [AW-1:0] tag_o
);

  logic          vld_q;
  logic [DW-1:0] data_q;
  logic [AW-1:0] tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
    end else if (clr_i) begin
      vld_q <= 1'b0;
    end else if (wr_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
      tag_q  <= tag_i;
    end else if (rd_i) begin
      vld_q <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign tag_o  = tag_q;

endmodule

// File: rtl/risc_fetch.sv
// Fetch unit: owns the PC, reads synchronous program memory, hands one word per cycle to decode.
// Define RISC_FETCH_BRANCH_EN to add the br_taken/br_target redirect from execute.
// state | meaning
// IDLE  | no reads issued, instr_vld low
// RUN   | one read per non-stalled cycle
// DRAIN | no new reads; finish in-flight/skid words, then IDLE
module risc_fetch
  import risc_pkg::*;
#(
  parameter int unsigned   AW     = 8,
  parameter int unsigned   IW     = risc_pkg::IW,
  parameter logic [AW-1:0] RST_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          stall,
`ifdef RISC_FETCH_BRANCH_EN
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
`endif
  output logic          pm_rd,
  output logic [AW-1:0] pm_addr,
  input  logic [IW-1:0] pm_data,
  output logic [IW-1:0] instr,
  output logic          instr_vld,
  output logic [AW-1:0] pc,
  output logic          busy
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          infl_q, infl_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          vld_q, vld_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          rd_en;
  logic          skid_wr, skid_rd, skid_clr, skid_vld;
  logic [IW-1:0] skid_data;
  logic [AW-1:0] skid_tag;

  risc_fetch_skid #(.DW(IW), .AW(AW)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_i   (skid_wr),
    .rd_i   (skid_rd),
    .clr_i  (skid_clr),
    .data_i (pm_data),
    .tag_i  (tag_q),
    .vld_o  (skid_vld),
    .data_o (skid_data),
    .tag_o  (skid_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RST_PC;
      infl_q     <= 1'b0;
      tag_q      <= RST_PC;
      instr_q    <= '0;
      vld_q      <= 1'b0;
      pc_q       <= RST_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      infl_q     <= infl_d;
      tag_q      <= tag_d;
      instr_q    <= instr_d;
      vld_q      <= vld_d;
      pc_q       <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    infl_d     = 1'b0;
    tag_d      = tag_q;
    instr_d    = instr_q;
    vld_d      = vld_q;
    pc_d       = pc_q;
    skid_wr    = 1'b0;
    skid_rd    = 1'b0;
    skid_clr   = 1'b0;
    rd_en      = (state_q == RUN) && !stall;
`ifdef RISC_FETCH_BRANCH_EN
    if (br_taken) rd_en = 1'b0;
`endif

    if (rd_en) begin
      fetch_pc_d = fetch_pc_q + AW'(1);
      infl_d     = 1'b1;
      tag_d      = fetch_pc_q;
    end

    // Skid and an arriving word never coincide: no read is issued while stalled.
    if (stall) begin
      skid_wr = infl_q;
    end else if (skid_vld) begin
      instr_d = skid_data;
      pc_d    = skid_tag;
      vld_d   = 1'b1;
      skid_rd = 1'b1;
    end else if (infl_q) begin
      instr_d = pm_data;
      pc_d    = tag_q;
      vld_d   = 1'b1;
    end else begin
      vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          fetch_pc_d = RST_PC;
        end
      end
      RUN: begin
        if (stop) state_d = DRAIN;
      end
      DRAIN: begin
        if (!skid_vld && !infl_q && (!vld_q || !stall)) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef RISC_FETCH_BRANCH_EN
    if (br_taken && (state_q != IDLE)) begin
      state_d    = RUN;
      fetch_pc_d = br_target;
      infl_d     = 1'b0;
      vld_d      = 1'b0;
      instr_d    = instr_q;
      pc_d       = pc_q;
      skid_wr    = 1'b0;
      skid_rd    = 1'b0;
      skid_clr   = 1'b1;
    end
`endif
  end

  assign pm_rd     = rd_en;
  assign pm_addr   = fetch_pc_q;
  assign instr     = instr_q;
  assign instr_vld = vld_q;
  assign pc        = pc_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_risc_fetch.sv
// Bench for risc_fetch: directed vector table, AW=4 wrap, reset/branch sequences, random run vs stream model.
module tb_risc_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, stop, stall, pm_rd, instr_vld, busy;
  logic [7:0]  pm_addr, pc;
  logic [15:0] pm_data, instr;
`ifdef RISC_FETCH_BRANCH_EN
  logic        br_taken, br_taken4;
  logic [7:0]  br_target;
  logic [3:0]  br_target4;
`endif
  logic        start4, stop4, stall4, pm_rd4, vld4, busy4;
  logic [3:0]  pm_addr4, pc4;
  logic [15:0] pm_data4, instr4;

  logic [15:0] mem  [256];
  logic [15:0] mem4 [16];

  always @(posedge clk) if (pm_rd)  pm_data  <= mem[pm_addr];
  always @(posedge clk) if (pm_rd4) pm_data4 <= mem4[pm_addr4];

  risc_fetch #(.AW(8), .IW(16), .RST_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .stall(stall),
`ifdef RISC_FETCH_BRANCH_EN
    .br_taken(br_taken), .br_target(br_target),
`endif
    .pm_rd(pm_rd), .pm_addr(pm_addr), .pm_data(pm_data),
    .instr(instr), .instr_vld(instr_vld), .pc(pc), .busy(busy)
  );

  risc_fetch #(.AW(4), .IW(16), .RST_PC(4'h0)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4), .stall(stall4),
`ifdef RISC_FETCH_BRANCH_EN
    .br_taken(br_taken4), .br_target(br_target4),
`endif
    .pm_rd(pm_rd4), .pm_addr(pm_addr4), .pm_data(pm_data4),
    .instr(instr4), .instr_vld(vld4), .pc(pc4), .busy(busy4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        stop;
    logic        vld;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic        rd;
    logic [7:0]  addr;
    logic        busy;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic st, input logic v, input logic [15:0] ins,
                              input logic [7:0] p, input logic r, input logic [7:0] a, input logic b);
    vec_t t;
    t.stall = s; t.stop = st; t.vld = v; t.instr = ins; t.pc = p; t.rd = r; t.addr = a; t.busy = b;
    return t;
  endfunction

  vec_t vecs [17];

  // Reference model: stream of issued-but-unconsumed words, tagged with issue cycle.
  typedef struct {
    logic [7:0] addr;
    int         cyc;
  } iss_t;

  iss_t       q[$];
  int         mst;
  logic [7:0] mfetch;
  int         ncyc;
  logic       prev_stall;

  task automatic mcycle(input logic s_stall, input logic s_start, input logic s_stop);
    logic exp_rd, exp_vld;
    @(negedge clk);
    stall = s_stall; start = s_start; stop = s_stop;
    #1;
    ncyc++;
    exp_rd  = (mst == 1) && !s_stall;
    exp_vld = (q.size() > 0) && (q[0].cyc <= ncyc - 2);
    chk("rnd_busy", 32'(busy), 32'(mst != 0));
    chk("rnd_pm_rd", 32'(pm_rd), 32'(exp_rd));
    if (exp_rd) chk("rnd_pm_addr", 32'(pm_addr), 32'(mfetch));
    if (!prev_stall || q.size() == 0) chk("rnd_vld", 32'(instr_vld), 32'(exp_vld));
    if (instr_vld) begin
      if (q.size() == 0) begin
        chk("rnd_spurious_vld", 32'(instr_vld), 32'(0));
      end else begin
        chk("rnd_pc", 32'(pc), 32'(q[0].addr));
        chk("rnd_instr", 32'(instr), 32'(mem[q[0].addr]));
        if (!s_stall) void'(q.pop_front());
      end
    end
    if (exp_rd) begin
      q.push_back('{addr: mfetch, cyc: ncyc});
      mfetch = mfetch + 8'd1;
    end
    if (mst == 1 && s_stop) mst = 2;
    else if (mst == 2 && q.size() == 0) mst = 0;
    else if (mst == 0 && s_start) begin
      mst = 1;
      mfetch = 8'h00;
    end
    prev_stall = s_stall;
  endtask

  function automatic logic rstall();
    return ($urandom_range(0, 99) < 30);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 16; i++) mem4[i] = 16'($urandom);
    mem[0] = 16'hE123; mem[1] = 16'hF234; mem[2] = 16'h0345; mem[3] = 16'h1456;

    vecs[0]  = mk(0, 0, 0, 16'h0000, 8'd0, 1, 8'd0, 1);
    vecs[1]  = mk(0, 0, 0, 16'h0000, 8'd0, 1, 8'd1, 1);
    vecs[2]  = mk(0, 0, 1, 16'hE123, 8'd0, 1, 8'd2, 1);
    vecs[3]  = mk(1, 0, 1, 16'hF234, 8'd1, 0, 8'd3, 1);
    vecs[4]  = mk(1, 0, 1, 16'hF234, 8'd1, 0, 8'd3, 1);
    vecs[5]  = mk(1, 0, 1, 16'hF234, 8'd1, 0, 8'd3, 1);
    vecs[6]  = mk(0, 0, 1, 16'hF234, 8'd1, 1, 8'd3, 1);
    vecs[7]  = mk(0, 0, 1, 16'h0345, 8'd2, 1, 8'd4, 1);
    vecs[8]  = mk(0, 0, 1, 16'h1456, 8'd3, 1, 8'd5, 1);
    vecs[9]  = mk(0, 0, 1, mem[4],   8'd4, 1, 8'd6, 1);
    vecs[10] = mk(1, 1, 1, mem[5],   8'd5, 0, 8'd7, 1);
    vecs[11] = mk(1, 0, 1, mem[5],   8'd5, 0, 8'd7, 1);
    vecs[12] = mk(1, 0, 1, mem[5],   8'd5, 0, 8'd7, 1);
    vecs[13] = mk(0, 0, 1, mem[5],   8'd5, 0, 8'd7, 1);
    vecs[14] = mk(0, 0, 1, mem[6],   8'd6, 0, 8'd7, 1);
    vecs[15] = mk(0, 0, 0, mem[6],   8'd6, 0, 8'd7, 0);
    vecs[16] = mk(0, 0, 0, mem[6],   8'd6, 0, 8'd7, 0);

    rst_n = 1'b0; start = 0; stop = 0; stall = 0;
    start4 = 0; stop4 = 0; stall4 = 0;
`ifdef RISC_FETCH_BRANCH_EN
    br_taken = 0; br_target = 8'h00; br_taken4 = 0; br_target4 = 4'h0;
`endif
    #23;
    chk("rst_instr", 32'(instr), 32'(0));
    chk("rst_vld", 32'(instr_vld), 32'(0));
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_pm_rd", 32'(pm_rd), 32'(0));
    chk("rst_pm_addr", 32'(pm_addr), 32'(0));
    @(negedge clk) rst_n = 1'b1;

    // Directed table: start, stream, 3-cycle stall with skid, stop under stall, drain.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      start = 1'b0; stall = vecs[k].stall; stop = vecs[k].stop;
      #1;
      chk($sformatf("vec%0d_vld", k),   32'(instr_vld), 32'(vecs[k].vld));
      chk($sformatf("vec%0d_instr", k), 32'(instr),     32'(vecs[k].instr));
      chk($sformatf("vec%0d_pc", k),    32'(pc),        32'(vecs[k].pc));
      chk($sformatf("vec%0d_pm_rd", k), 32'(pm_rd),     32'(vecs[k].rd));
      chk($sformatf("vec%0d_addr", k),  32'(pm_addr),   32'(vecs[k].addr));
      chk($sformatf("vec%0d_busy", k),  32'(busy),      32'(vecs[k].busy));
    end
    stall = 0; stop = 0;

    // AW=4 instance: address and pc wrap 15 -> 0.
    @(negedge clk) start4 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      #1;
      chk($sformatf("wrap%0d_addr", k), 32'(pm_addr4), 32'(k % 16));
      if (k >= 2) begin
        chk($sformatf("wrap%0d_vld", k), 32'(vld4), 32'(1));
        chk($sformatf("wrap%0d_pc", k), 32'(pc4), 32'((k - 2) % 16));
        chk($sformatf("wrap%0d_instr", k), 32'(instr4), 32'(mem4[(k - 2) % 16]));
      end
    end
    @(negedge clk) stop4 = 1'b1;
    @(negedge clk) stop4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("wrap_idle", 32'(busy4), 32'(0));

    // Randomised runs against the stream model.
    mst = 0; mfetch = 8'h00; ncyc = 0; prev_stall = 1'b0; q.delete();
    for (int r = 0; r < 4; r++) begin
      int n;
      n = 40 + int'($urandom_range(0, 20));
      mcycle(rstall(), 1'b1, 1'b0);
      for (int i = 0; i < n; i++) mcycle(rstall(), ($urandom_range(0, 9) == 0), 1'b0);
      mcycle(rstall(), 1'b0, 1'b1);
      for (int i = 0; i < 100 && mst != 0; i++) mcycle(rstall(), 1'b0, 1'b0);
      mcycle(rstall(), 1'b0, 1'b0);
      chk($sformatf("rnd%0d_idle", r), 32'(busy), 32'(0));
    end
    @(negedge clk) stall = 1'b0;

    // Async reset with skid full, then restart from RST_PC.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk) stall = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(instr_vld), 32'(0));
    chk("arst_pc", 32'(pc), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_pm_rd", 32'(pm_rd), 32'(0));
    @(negedge clk) begin rst_n = 1'b1; stall = 1'b0; end
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk($sformatf("restart%0d_vld", k), 32'(instr_vld), 32'(k >= 2));
      if (k >= 2) begin
        chk($sformatf("restart%0d_pc", k), 32'(pc), 32'(k - 2));
        chk($sformatf("restart%0d_instr", k), 32'(instr), 32'(mem[k - 2]));
      end
    end
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    repeat (4) @(negedge clk);
    chk("restart_idle", 32'(busy), 32'(0));

`ifdef RISC_FETCH_BRANCH_EN
    // Branch while stalled: in-flight word dropped, next word comes from the target.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      start = 1'b0;
      stall = (k == 3);
      br_taken = (k == 3);
      br_target = 8'h40;
      #1;
      if (k == 3) chk("br_pm_rd", 32'(pm_rd), 32'(0));
      if (k == 4) begin
        chk("br_vld_next", 32'(instr_vld), 32'(0));
        chk("br_addr", 32'(pm_addr), 32'(8'h40));
        chk("br_pm_rd_resume", 32'(pm_rd), 32'(1));
      end
      if (k == 5) chk("br_bubble", 32'(instr_vld), 32'(0));
      if (k == 6) begin
        chk("br_vld", 32'(instr_vld), 32'(1));
        chk("br_pc", 32'(pc), 32'(8'h40));
        chk("br_instr", 32'(instr), 32'(mem[8'h40]));
      end
    end
    br_taken = 1'b0;
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    repeat (4) @(negedge clk);
    chk("br_idle", 32'(busy), 32'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
